router_reg_param: RTL
=====================

// Module: router_reg_param
// PURPOSE
//  Parametrised packet data register for the router datapath, between the input port and the
//  per-channel FIFOs under control of the router FSM. Latches the header, forwards header and
//  payload to dout, holds one byte while the FIFO is full, and accumulates a running check.
//  Checks the trailing check byte and the header length field: err (check), len_err, addr_err.
// PARAMETERS
//  DATA_W   8  byte width of data_in/dout
//  ADDR_W   2  header address field width, header[ADDR_W-1:0]; length = header[DATA_W-1:ADDR_W]
//  NUM_CH   3  number of valid destinations; address >= NUM_CH is illegal
//  CHK_MODE 0  0 = XOR parity; 1 = sum modulo 2^DATA_W
// PORTS
//  clock            in   1       rising-edge clock
//  resetn           in   1       asynchronous active-low reset
//  pkt_valid        in   1       packet byte valid; falls on the check byte
//  data_in          in   DATA_W  header / payload / check byte
//  fifo_full        in   1       selected FIFO full
//  detect_add       in   1       FSM DECODE_ADDRESS state
//  lfd_state        in   1       FSM LOAD_FIRST_DATA state
//  ld_state         in   1       FSM LOAD_DATA state
//  laf_state        in   1       FSM LOAD_AFTER_FULL state
//  full_state       in   1       FSM FIFO_FULL_STATE; freezes all registers except low_packet_valid
//  rst_int_reg      in   1       clears low_packet_valid
//  dout             out  DATA_W  byte to FIFO
//  parity_done      out  1       check byte captured
//  low_packet_valid out  1       packet ended in LOAD_DATA
//  err              out  1       check mismatch, sticky
//  len_err          out  1       payload count != header length, sticky
//  addr_err         out  1       one-cycle pulse: illegal address on header
//  hold_valid       out  1       holding register occupied
// BEHAVIOUR
//  - Reset: all outputs and internal regs (header, hold, chk, ext_chk, cnt, hold_is_chk) = 0.
//  - Priority per cycle: detect_add > lfd_state > ld_state > laf_state; full_state blocks all.
//  - detect_add & pkt_valid, addr < NUM_CH: header <= data_in; chk, cnt, err, len_err and
//    parity_done cleared. addr >= NUM_CH: addr_err = 1 next cycle for 1 cycle; header unchanged.
//  - lfd_state: dout <= header; chk <= chk OP header (OP = ^ or +, truncated to DATA_W).
//  - ld_state & pkt_valid: chk <= chk OP data_in; cnt++ (LEN_W = DATA_W-ADDR_W bits, saturates).
//    If !fifo_full, dout <= data_in; else hold <= data_in, hold_valid <= 1.
//  - ld_state & !pkt_valid: check byte; low_packet_valid <= 1. If !fifo_full, dout <= data_in,
//    ext_chk <= data_in, parity_done <= 1. Else hold <= data_in, hold_valid <= 1, hold_is_chk <= 1.
//  - laf_state & hold_valid: dout <= hold; hold_valid <= 0. If hold_is_chk: ext_chk <= hold,
//    parity_done <= 1, hold_is_chk <= 0. laf_state with hold empty: no change.
//  - Check: the cycle after parity_done rises, err <= (chk != ext_chk) and
//    len_err <= (cnt != header length). Both stay set until the next legal header.
//    parity_done stays 1 until then; the compare is not re-evaluated.
//  - low_packet_valid: rst_int_reg wins over set; otherwise holds.
//  - Latency: 1 cycle from data_in to dout; err/len_err 1 cycle after parity_done.
//  - Reset mid-packet: every register clears at once; the next packet needs detect_add.
//  - Length 0: no payload bytes; len_err = 0 only if the check byte follows lfd directly.
// TESTING (DATA_W=8, ADDR_W=2, NUM_CH=3)
//  - XOR: header 0x16 (len 5, addr 2), payload 01..05, check 0x17 -> dout seq 16,01..05,17;
//    parity_done=1, err=0, len_err=0.
//  - Same packet, check 0x2E -> err=1 one cycle after parity_done; held until next detect_add.
//  - CHK_MODE=1: same payload, check 0x25 -> err=0; check 0x17 -> err=1.
//  - Header 0x16, only 4 payload bytes, check byte correct for those bytes -> err=0, len_err=1.
//  - Header 0x07 (addr 3) -> addr_err one-cycle pulse; header reg unchanged.
//  - fifo_full on byte 3 -> hold=03, hold_valid=1; full_state freezes; laf -> dout=03, hold_valid=0.
//  - fifo_full on check byte -> parity_done in laf; err=0.
//  - resetn low for 3 ns mid-payload, between clock edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/router_reg_if.sv
// rtl/router_reg_if.sv - router packet register bus: FSM state strobes, FIFO-side data and status flags
interface router_reg_if #(
  parameter int DATA_W = 8
);
  logic              pkt_valid;
  logic [DATA_W-1:0] data_in;
  logic              fifo_full;
  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              rst_int_reg;
  logic [DATA_W-1:0] dout;
  logic              parity_done;
  logic              low_packet_valid;
  logic              err;
  logic              len_err;
  logic              addr_err;
  logic              hold_valid;

  modport master (
    output pkt_valid, data_in, fifo_full, detect_add, lfd_state, ld_state,
           laf_state, full_state, rst_int_reg,
    input  dout, parity_done, low_packet_valid, err, len_err, addr_err, hold_valid
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, detect_add, lfd_state, ld_state,
           laf_state, full_state, rst_int_reg,
    output dout, parity_done, low_packet_valid, err, len_err, addr_err, hold_valid
  );
endinterface

// File: rtl/router_reg_param.sv
// rtl/router_reg_param.sv - router packet data register with one-byte hold, running check and length/address checks
module router_reg_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter int NUM_CH   = 3,
  parameter int CHK_MODE = 0
) (
  input logic         clock,
  input logic         resetn,
  router_reg_if.slave bus
);
  localparam int          LEN_W    = DATA_W - ADDR_W;
  localparam logic [31:0] NUM_CH_U = NUM_CH;

  logic [DATA_W-1:0] header;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] chk;
  logic [DATA_W-1:0] ext_chk;
  logic [LEN_W-1:0]  cnt;
  logic              hold_is_chk;
  logic              cmp_pend;
  logic              addr_ok;

  function automatic logic [DATA_W-1:0] chk_op(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    if (CHK_MODE == 1) return a + b;
    else               return a ^ b;
  endfunction

  assign addr_ok = 32'(bus.data_in[ADDR_W-1:0]) < NUM_CH_U;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      header               <= '0;
      hold                 <= '0;
      chk                  <= '0;
      ext_chk              <= '0;
      cnt                  <= '0;
      hold_is_chk          <= 1'b0;
      cmp_pend             <= 1'b0;
      bus.dout             <= '0;
      bus.parity_done      <= 1'b0;
      bus.low_packet_valid <= 1'b0;
      bus.err              <= 1'b0;
      bus.len_err          <= 1'b0;
      bus.addr_err         <= 1'b0;
      bus.hold_valid       <= 1'b0;
    end else begin
      bus.addr_err <= 1'b0;
      if (bus.rst_int_reg) bus.low_packet_valid <= 1'b0;

      if (!bus.full_state) begin
        // Single compare on the cycle after parity_done rises; results stay sticky.
        if (cmp_pend) begin
          bus.err     <= (chk != ext_chk);
          bus.len_err <= (cnt != header[DATA_W-1:ADDR_W]);
          cmp_pend    <= 1'b0;
        end

        if (bus.detect_add) begin
          if (bus.pkt_valid) begin
            if (addr_ok) begin
              header          <= bus.data_in;
              chk             <= '0;
              cnt             <= '0;
              bus.err         <= 1'b0;
              bus.len_err     <= 1'b0;
              bus.parity_done <= 1'b0;
              cmp_pend        <= 1'b0;
            end else begin
              bus.addr_err <= 1'b1;
            end
          end
        end else if (bus.lfd_state) begin
          bus.dout <= header;
          chk      <= chk_op(chk, header);
        end else if (bus.ld_state) begin
          if (bus.pkt_valid) begin
            chk <= chk_op(chk, bus.data_in);
            if (cnt != '1) cnt <= cnt + LEN_W'(1);
            if (!bus.fifo_full) begin
              bus.dout <= bus.data_in;
            end else begin
              hold           <= bus.data_in;
              bus.hold_valid <= 1'b1;
            end
          end else begin
            if (!bus.rst_int_reg) bus.low_packet_valid <= 1'b1;
            if (!bus.fifo_full) begin
              bus.dout        <= bus.data_in;
              ext_chk         <= bus.data_in;
              bus.parity_done <= 1'b1;
              if (!bus.parity_done) cmp_pend <= 1'b1;
            end else begin
              hold           <= bus.data_in;
              bus.hold_valid <= 1'b1;
              hold_is_chk    <= 1'b1;
            end
          end
        end else if (bus.laf_state && bus.hold_valid) begin
          bus.dout       <= hold;
          bus.hold_valid <= 1'b0;
          if (hold_is_chk) begin
            ext_chk         <= hold;
            bus.parity_done <= 1'b1;
            hold_is_chk     <= 1'b0;
            if (!bus.parity_done) cmp_pend <= 1'b1;
          end
        end
      end
    end
  end
endmodule
